// File: rtl/interrupt_controller.sv
// Fixed-priority interrupt controller: latches peripheral event pulses as pending and
// presents one enabled source at a time to the CPU over an irq/ack/done handshake.
module interrupt_controller #(
  parameter logic [7:0] INTERRUPT_CONTROLLER_ADDRESS = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] din,
  input  logic [7:0] address,
  input  logic       w_en,
  input  logic       r_en,
  output logic [7:0] dout,
  input  logic [7:0] src,
  output logic       irq,
  output logic [2:0] vector,
  input  logic       ack,
  input  logic       done
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t     state, state_n;
  logic [7:0] enable;
  logic [7:0] pending, pending_n;
  logic       ctl_en;
  logic [7:0] off;
  logic       hit;
  logic [7:0] eligible;
  logic [2:0] winner;
  logic       found;
  logic [2:0] vector_n;
  logic       irq_n;
  logic       ack_clr;
  logic [7:0] w1c;
  logic [7:0] rdata;

  assign off      = address - INTERRUPT_CONTROLLER_ADDRESS;
  assign hit      = (off[7:2] == 6'd0);
  assign eligible = ctl_en ? (pending & enable) : '0;
  assign w1c      = (w_en && hit && off[1:0] == 2'd1) ? din : '0;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (eligible[i] && !found) begin
        winner = 3'(i);
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_n  = state;
    irq_n    = irq;
    vector_n = vector;
    ack_clr  = 1'b0;
    case (state)
      IDLE: begin
        if (eligible != '0) begin
          state_n  = REQ;
          vector_n = winner;
          irq_n    = 1'b1;
        end
      end
      REQ: begin
        // ack wins over withdrawal; vector stays frozen while requesting
        if (ack) begin
          state_n = SERVICE;
          irq_n   = 1'b0;
          ack_clr = 1'b1;
        end else if (!(pending[vector] && enable[vector] && ctl_en)) begin
          state_n = IDLE;
          irq_n   = 1'b0;
        end
      end
      SERVICE: begin
        if (done) state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        irq_n   = 1'b0;
      end
    endcase
  end

  // New events override any clear arriving in the same cycle
  assign pending_n = (pending & ~(w1c | (ack_clr ? (8'd1 << vector) : 8'd0))) | src;

  always_comb begin
    rdata = '0;
    if (hit) begin
      case (off[1:0])
        2'd0:    rdata = enable;
        2'd1:    rdata = pending;
        2'd2:    rdata = {4'b0, state == SERVICE, vector};
        default: rdata = {7'b0, ctl_en};
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      enable  <= '0;
      pending <= '0;
      ctl_en  <= 1'b0;
      dout    <= '0;
      irq     <= 1'b0;
      vector  <= '0;
    end else begin
      state   <= state_n;
      irq     <= irq_n;
      vector  <= vector_n;
      pending <= pending_n;
      if (r_en) dout <= rdata;
      if (w_en && hit && off[1:0] == 2'd0) enable <= din;
      if (w_en && hit && off[1:0] == 2'd3) ctl_en <= din[0];
    end
  end

endmodule

// File: tb/tb_interrupt_controller.sv
// Self-checking bench for interrupt_controller: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a behavioural model.
module tb_interrupt_controller;

  localparam logic [7:0] BASE = 8'h40;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din, address, src;
  logic       w_en, r_en, ack, done;
  logic [7:0] dout;
  logic       irq;
  logic [2:0] vector;

  int checks = 0;
  int errors = 0;

  interrupt_controller #(.INTERRUPT_CONTROLLER_ADDRESS(BASE)) dut (
    .clk(clk), .rst(rst), .din(din), .address(address), .w_en(w_en), .r_en(r_en),
    .dout(dout), .src(src), .irq(irq), .vector(vector), .ack(ack), .done(done)
  );

  always #5 clk = ~clk;

  // Behavioural model: phase 0 = idle, 1 = requesting, 2 = in service
  logic [7:0] m_pend, m_en, m_dout;
  logic       m_ctl, m_irq;
  logic [2:0] m_vec;
  int         m_phase;

  function automatic int lowest(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_step();
    logic [7:0] clr, elig;
    int off, w;
    if (rst) begin
      m_pend = '0; m_en = '0; m_ctl = 0; m_dout = '0;
      m_irq = 0; m_vec = '0; m_phase = 0;
      return;
    end
    off  = int'(address) - int'(BASE);
    clr  = '0;
    elig = m_ctl ? (m_pend & m_en) : 8'h00;
    if (r_en) begin
      if (off == 0)      m_dout = m_en;
      else if (off == 1) m_dout = m_pend;
      else if (off == 2) m_dout = {4'b0, m_phase == 2, m_vec};
      else if (off == 3) m_dout = {7'b0, m_ctl};
      else               m_dout = 8'h00;
    end
    if (m_phase == 0) begin
      w = lowest(elig);
      if (w >= 0) begin m_phase = 1; m_vec = 3'(w); m_irq = 1; end
    end else if (m_phase == 1) begin
      if (ack) begin
        m_phase = 2; m_irq = 0; clr[m_vec] = 1'b1;
      end else if (!(m_pend[m_vec] && m_en[m_vec] && m_ctl)) begin
        m_phase = 0; m_irq = 0;
      end
    end else if (done) begin
      m_phase = 0;
    end
    if (w_en && off == 0) m_en = din;
    if (w_en && off == 1) clr = clr | din;
    if (w_en && off == 3) m_ctl = din[0];
    m_pend = (m_pend & ~clr) | src;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    model_step();
    #1;
    check("irq", {7'b0, irq}, {7'b0, m_irq});
    check("vector", {5'b0, vector}, {5'b0, m_vec});
    check("dout", dout, m_dout);
  end

  // Advance one cycle; pulse-type inputs last exactly one cycle
  task automatic cyc();
    @(negedge clk);
    src = '0; ack = 0; done = 0; w_en = 0; r_en = 0;
  endtask

  task automatic wr(input logic [7:0] off, input logic [7:0] d);
    address = BASE + off; din = d; w_en = 1; cyc();
  endtask

  task automatic rd(input logic [7:0] off);
    address = BASE + off; r_en = 1; cyc();
  endtask

  initial begin
    rst = 1; src = '0; ack = 0; done = 0; w_en = 0; r_en = 0; din = '0; address = '0;
    cyc(); cyc();
    check("reset_irq", {7'b0, irq}, 8'h00);
    check("reset_dout", dout, 8'h00);
    rst = 0;

    // single source, 2-clock latency
    wr(0, 8'h01); wr(3, 8'h01);
    src = 8'h01; cyc();
    check("t1_irq_early", {7'b0, irq}, 8'h00);
    cyc();
    check("t1_irq", {7'b0, irq}, 8'h01);
    check("t1_vec", {5'b0, vector}, 8'h00);
    ack = 1; cyc();
    check("t1_irq_ack", {7'b0, irq}, 8'h00);
    rd(1); check("t1_pend", dout, 8'h00);
    done = 1; cyc();
    rd(2); check("t1_status", dout, 8'h00);

    // two simultaneous sources served by priority
    wr(0, 8'hFF);
    src = 8'h24; cyc(); cyc();
    check("t2_vec_first", {5'b0, vector}, 8'h02);
    ack = 1; cyc(); done = 1; cyc(); cyc();
    check("t2_irq_second", {7'b0, irq}, 8'h01);
    check("t2_vec_second", {5'b0, vector}, 8'h05);
    ack = 1; cyc(); done = 1; cyc();
    rd(1); check("t2_pend_end", dout, 8'h00);

    // pending latches while disabled
    wr(0, 8'h00);
    src = 8'h08; cyc(); cyc();
    check("t3_irq_off", {7'b0, irq}, 8'h00);
    rd(1); check("t3_pend", dout, 8'h08);
    wr(0, 8'h08); cyc();
    check("t3_irq", {7'b0, irq}, 8'h01);
    check("t3_vec", {5'b0, vector}, 8'h03);
    ack = 1; cyc(); done = 1; cyc();

    // W1C withdraws a request; simultaneous event keeps it
    wr(0, 8'h02);
    src = 8'h02; cyc(); cyc();
    check("t4_irq", {7'b0, irq}, 8'h01);
    wr(1, 8'h02); cyc();
    check("t4_withdrawn", {7'b0, irq}, 8'h00);
    src = 8'h02; cyc(); cyc();
    src = 8'h02; wr(1, 8'h02); cyc();
    check("t4_kept", {7'b0, irq}, 8'h01);
    rd(1); check("t4_pend", dout, 8'h02);
    ack = 1; cyc(); done = 1; cyc();

    // event coinciding with ack stays pending
    wr(0, 8'h10);
    src = 8'h10; cyc(); cyc();
    check("t5_vec", {5'b0, vector}, 8'h04);
    ack = 1; src = 8'h10; cyc();
    rd(1); check("t5_pend", dout, 8'h10);
    done = 1; cyc(); cyc();
    check("t5_reassert", {7'b0, irq}, 8'h01);
    check("t5_vec2", {5'b0, vector}, 8'h04);
    ack = 1; cyc(); done = 1; cyc();

    // reset in service
    wr(0, 8'hFF);
    src = 8'hF0; cyc(); cyc();
    ack = 1; cyc();
    src = 8'hF0; cyc();
    rd(1); check("t6_pend_pre", dout, 8'hF0);
    rst = 1; cyc(); rst = 0;
    check("t6_irq", {7'b0, irq}, 8'h00);
    check("t6_vec", {5'b0, vector}, 8'h00);
    check("t6_dout", dout, 8'h00);
    rd(1); check("t6_pend", dout, 8'h00);
    rd(0); check("t6_en", dout, 8'h00);
    rd(3); check("t6_ctl", dout, 8'h00);
    wr(0, 8'hAA); rd(0); check("t6_en_rw", dout, 8'hAA);
    rd(5); check("t6_unmapped", dout, 8'h00);

    // randomized traffic
    wr(3, 8'h01);
    for (int n = 0; n < 4000; n++) begin
      src  = ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'h00;
      ack  = ($urandom_range(0, 2) == 0);
      done = ($urandom_range(0, 3) == 0);
      address = BASE + 8'($urandom_range(0, 5));
      din  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h01;
      w_en = ($urandom_range(0, 5) == 0);
      r_en = ($urandom_range(0, 1) == 0);
      rst  = ($urandom_range(0, 399) == 0);
      cyc();
      rst = 0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
